// File: rtl/alu_operand_stage_if.sv
// Bundles the request, writeback and ALU-side signals of alu_operand_stage.
// master: the side that issues requests and consumes operands.
// slave: the operand stage itself.
interface alu_operand_stage_if #(
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    rs_addr;
  logic [4:0]    rt_addr;
  logic [DW-1:0] imm;
  logic          use_imm;
  logic [2:0]    alu_op_in;
  logic          we;
  logic [4:0]    wa;
  logic [DW-1:0] wd;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] A;
  logic [DW-1:0] B;
  logic [2:0]    ALUOp;

  modport master (
    output in_valid, rs_addr, rt_addr, imm, use_imm, alu_op_in,
    output we, wa, wd, out_ready,
    input  in_ready, out_valid, A, B, ALUOp
  );

  modport slave (
    input  in_valid, rs_addr, rt_addr, imm, use_imm, alu_op_in,
    input  we, wa, wd, out_ready,
    output in_ready, out_valid, A, B, ALUOp
  );
endinterface

// File: rtl/alu_operand_stage.sv
// EX-input operand stage: general register file, operand selection and a
// single-entry valid/ready buffer that presents stable {A, B, ALUOp} to the ALU.
// Optional feature macro: OPS_SHIFT_MASK_EN -- when defined, B is limited to
// its low 5 bits for the shift opcodes (4 srl, 5 sra).
module alu_operand_stage #(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input logic              clk,
  input logic              reset,
  alu_operand_stage_if.slave bus
);

  logic [DW-1:0] grf [NREG];

  logic          out_valid_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [2:0]    op_q;

  logic          accept;
  logic [DW-1:0] a_sel;
  logic [DW-1:0] rt_val;
  logic [DW-1:0] b_sel;
  logic [DW-1:0] b_cap;

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.ALUOp     = op_q;

  assign accept = bus.in_valid && bus.in_ready;

  // Register reads: $0 is hard zero, a same-cycle writeback to the read address is forwarded.
  always_comb begin
    a_sel  = '0;
    rt_val = '0;
    if (bus.rs_addr != 5'd0) begin
      a_sel = (bus.we && (bus.wa == bus.rs_addr)) ? bus.wd : grf[bus.rs_addr];
    end
    if (bus.rt_addr != 5'd0) begin
      rt_val = (bus.we && (bus.wa == bus.rt_addr)) ? bus.wd : grf[bus.rt_addr];
    end
  end

  // Operand B selection, optionally trimmed to a legal shift amount.
  always_comb begin
    b_sel = bus.use_imm ? bus.imm : rt_val;
`ifdef OPS_SHIFT_MASK_EN
    if ((bus.alu_op_in == 3'd4) || (bus.alu_op_in == 3'd5)) begin
      b_cap = {{(DW-5){1'b0}}, b_sel[4:0]};
    end else begin
      b_cap = b_sel;
    end
`else
    b_cap = b_sel;
`endif
  end

  // Register file writeback; $0 is never written so it stays zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        grf[i] <= '0;
      end
    end else if (bus.we && (bus.wa != 5'd0)) begin
      grf[bus.wa] <= bus.wd;
    end
  end

  // Output buffer: load on accept, drop valid on consume-only, hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      a_q         <= a_sel;
      b_q         <= b_cap;
      op_q        <= bus.alu_op_in;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: a vector table plus hand-written
// stall, back-to-back, snapshot and reset sequences, with a scoreboard queue
// filled on accept and drained on consume.
module tb_alu_operand_stage;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        vld;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] imm;
    logic        ui;
    logic [2:0]  op;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  exp_t sbq[$];
  exp_t cur_exp;
  exp_t mon_e;

  vec_t tbl[9];
  vec_t b2b[4];

  alu_operand_stage_if #(.DW(32)) bus ();

  alu_operand_stage #(.NREG(32), .DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] shmask(input logic [31:0] v, input logic [2:0] op);
`ifdef OPS_SHIFT_MASK_EN
    if (op == 3'd4 || op == 3'd5) return {27'b0, v[4:0]};
`endif
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.we        = v.we;
    bus.wa        = v.wa;
    bus.wd        = v.wd;
    bus.in_valid  = v.vld;
    bus.rs_addr   = v.rs;
    bus.rt_addr   = v.rt;
    bus.imm       = v.imm;
    bus.use_imm   = v.ui;
    bus.alu_op_in = v.op;
    cur_exp       = '{a: v.ea, b: v.eb, op: v.op};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop/compare on consume, then push on accept.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out_valid && bus.out_ready) begin
        if (sbq.size() == 0) begin
          check("sb_unexpected_output", 32'd1, 32'd0);
        end else begin
          mon_e = sbq.pop_front();
          check("out_A", bus.A, mon_e.a);
          check("out_B", bus.B, mon_e.b);
          check("out_ALUOp", {29'd0, bus.ALUOp}, {29'd0, mon_e.op});
        end
      end
      if (bus.in_valid && bus.in_ready) sbq.push_back(cur_exp);
    end
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;

    //        we  wa  wd            vld rs  rt  imm           ui  op  ea            eb
    tbl[0] = '{1, 5, 32'h1234_5678, 0, 0,  0,  32'h0,        0, 0, 32'h0,        32'h0};
    tbl[1] = '{0, 0, 32'h0,         1, 5,  0,  32'h0,        0, 0, 32'h1234_5678, 32'h0};
    tbl[2] = '{1, 7, 32'hDEAD_BEEF, 1, 7,  0,  32'hFFFF_FFFC, 1, 1, 32'hDEAD_BEEF, 32'hFFFF_FFFC};
    tbl[3] = '{1, 0, 32'hAAAA_5555, 1, 0,  0,  32'h0,        0, 2, 32'h0,        32'h0};
    tbl[4] = '{1, 2, 32'h0000_0123, 1, 5,  7,  32'h0,        0, 3, 32'h1234_5678, 32'hDEAD_BEEF};
    tbl[5] = '{0, 0, 32'h0,         1, 7,  2,  32'h0,        0, 5, 32'hDEAD_BEEF, shmask(32'h0000_0123, 3'd5)};
    tbl[6] = '{1, 2, 32'hFFFF_FFE1, 1, 2,  2,  32'h0,        0, 4, 32'hFFFF_FFE1, shmask(32'hFFFF_FFE1, 3'd4)};
    tbl[7] = '{0, 0, 32'h0,         1, 0,  0,  32'h0000_002A, 1, 4, 32'h0,        shmask(32'h0000_002A, 3'd4)};
    tbl[8] = '{0, 0, 32'h0,         1, 2,  5,  32'h0,        0, 2, 32'hFFFF_FFE1, 32'h1234_5678};

    b2b[0] = '{0, 0, 32'h0, 1, 5, 7, 32'h0,        0, 2, 32'h1234_5678, 32'hDEAD_BEEF};
    b2b[1] = '{0, 0, 32'h0, 1, 7, 0, 32'h0000_0011, 1, 3, 32'hDEAD_BEEF, 32'h0000_0011};
    b2b[2] = '{0, 0, 32'h0, 1, 3, 3, 32'h0,        0, 0, 32'd99,        32'd99};
    b2b[3] = '{0, 0, 32'h0, 1, 2, 0, 32'h0000_0025, 1, 5, 32'hFFFF_FFE1, shmask(32'h0000_0025, 3'd5)};

    reset = 1'b0;
    drive('{0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0});
    bus.out_ready = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_A", bus.A, 32'd0);
    check("rst_B", bus.B, 32'd0);
    check("rst_ALUOp", {29'd0, bus.ALUOp}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    step();

    bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i]);
      step();
    end

    // Snapshot and stall: $3=10, capture it, then overwrite $3 while stalled.
    drive('{1, 3, 32'd10, 0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0});
    step();
    drive('{0, 0, 32'h0, 1, 3, 5, 32'h0, 0, 0, 32'd10, 32'h1234_5678});
    step();
    bus.out_ready = 1'b0;
    drive('{1, 3, 32'd99, 1, 3, 0, 32'h0, 0, 1, 32'd99, 32'h0});
    for (int k = 0; k < 3; k++) begin
      #3;
      check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("stall_A", bus.A, 32'd10);
      check("stall_B", bus.B, 32'h1234_5678);
      check("stall_ALUOp", {29'd0, bus.ALUOp}, 32'd0);
      step();
      bus.we = 1'b0;
    end
    bus.out_ready = 1'b1;
    #3;
    check("unstall_in_ready", {31'd0, bus.in_ready}, 32'd1);
    step();

    // Back-to-back: one output per cycle with no bubble.
    for (int j = 0; j < 4; j++) begin
      drive(b2b[j]);
      #3;
      check("b2b_out_valid", {31'd0, bus.out_valid}, 32'd1);
      step();
    end
    bus.in_valid = 1'b0;
    #3;
    check("b2b_last_valid", {31'd0, bus.out_valid}, 32'd1);
    step();
    #3;
    check("drain_out_valid", {31'd0, bus.out_valid}, 32'd0);
    step();

    // Reset while a request is stalled in the buffer.
    drive('{0, 0, 32'h0, 1, 5, 7, 32'h0, 0, 4, 32'h0, 32'h0});
    step();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("async_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("async_rst_A", bus.A, 32'd0);
    check("async_rst_B", bus.B, 32'd0);
    check("async_rst_ALUOp", {29'd0, bus.ALUOp}, 32'd0);
    sbq.delete();
    #1 reset = 1'b0;
    step();

    bus.out_ready = 1'b1;
    drive('{0, 0, 32'h0, 1, 5, 7, 32'h0, 0, 0, 32'h0, 32'h0});
    step();
    drive('{0, 0, 32'h0, 1, 3, 2, 32'h0, 0, 1, 32'h0, 32'h0});
    step();
    bus.in_valid = 1'b0;
    step();
    step();

    check("sb_drained", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
